// File: rtl/multicycle_adder_if.sv
// -----------------------------------------------------------------------------
// multicycle_adder_if
//
// Purpose : bundles the operand-side and result-side valid/ready handshakes of
//           the digit-serial adder into one interface.
//
// Signals :
//   in_valid  - operands a, b, cin, sub are valid            (master -> slave)
//   in_ready  - adder can accept operands this cycle         (slave  -> master)
//   a, b      - WIDTH-bit operands                           (master -> slave)
//   cin       - carry-in (add) / borrow-in (subtract)        (master -> slave)
//   sub       - subtract request                             (master -> slave)
//   out_valid - sum, cout, ovf are valid                     (slave  -> master)
//   out_ready - consumer accepts the result                  (master -> slave)
//   sum       - WIDTH-bit result                             (slave  -> master)
//   cout      - carry-out (add) / borrow-out (subtract)      (slave  -> master)
//   ovf       - signed overflow                              (slave  -> master)
//   busy      - adder is stepping through digits             (slave  -> master)
//
// Modports: master drives operands and consumes results; slave is the adder.
// WIDTH must match the WIDTH parameter of the attached multicycle_adder.
// -----------------------------------------------------------------------------
interface multicycle_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  ovf,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output ovf,
        output busy
    );
endinterface

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//
// Purpose : digit-serial adder/subtractor. Two WIDTH-bit operands are summed
//           DIGIT bits per clock through a registered carry, giving the
//           WIDTH-bit sum, carry/borrow out and signed overflow after
//           NDIG = WIDTH/DIGIT run cycles. Trades latency for a narrow adder.
//
// Parameters:
//   WIDTH - operand/result width, >= 2 and a multiple of DIGIT
//   DIGIT - bits added per run cycle, 1 <= DIGIT <= WIDTH
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset, clears every register
//   bus   - multicycle_adder_if.slave: operand handshake (in_valid/in_ready,
//           a, b, cin, sub), result handshake (out_valid/out_ready, sum,
//           cout, ovf) and busy
//
// Build option:
//   MULTICYCLE_ADDER_SUB_EN - when defined, sub is latched on accept and
//           sub=1 computes a - b - cin (b inverted, initial carry ~cin, cout
//           reports borrow-out). When undefined the sub input is ignored and
//           the block is a pure adder.
//
// Timing: accept on edge E0, run beats on E1..E_NDIG, out_valid high after
// E_NDIG. in_ready is the only output with a combinational input path (from
// out_ready, to allow back-to-back acceptance while a result is consumed).
// -----------------------------------------------------------------------------
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_adder_if.slave    bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

    // Reject illegal geometry at elaboration time.
    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH < 2)) begin : g_bad_digit
            $error("multicycle_adder: need WIDTH >= 2 and 1 <= DIGIT <= WIDTH");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_multiple
            $error("multicycle_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [WIDTH-1:0]  sa_r;
    logic [WIDTH-1:0]  sb_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic              cout_r;
    logic              ovf_r;
    logic [CW-1:0]     cnt_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              last_beat_s;
    logic [DIGIT:0]    digit_sum_s;
    logic              msb_cin_s;
    logic              final_carry_s;
    logic [WIDTH-1:0]  sa_next_s;
    logic [WIDTH-1:0]  sb_next_s;
    logic [WIDTH-1:0]  sum_next_s;

    // Operand conditioning applied at the accept edge.
    logic [WIDTH-1:0]  b_in_s;
    logic              carry_in_s;
    logic              sub_mode_s;

`ifdef MULTICYCLE_ADDER_SUB_EN
    logic              sub_r;

    // Subtraction is a + ~b + ~cin; condition b and the carry on the way in.
    always_comb begin
        b_in_s     = bus.b;
        carry_in_s = bus.cin;
        if (bus.sub) begin
            b_in_s     = ~bus.b;
            carry_in_s = ~bus.cin;
        end else begin
            b_in_s     = bus.b;
            carry_in_s = bus.cin;
        end
    end

    assign sub_mode_s = sub_r;

    // Mode bit captured with the operands so cout can report borrow-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_r <= 1'b0;
        end else if (accept_s) begin
            sub_r <= bus.sub;
        end else begin
            sub_r <= sub_r;
        end
    end
`else
    // sub is present on the interface but has no effect in the adder-only build.
    logic              unused_sub_s;
    assign unused_sub_s = bus.sub;

    // Adder-only build: operands pass straight through.
    always_comb begin
        b_in_s     = bus.b;
        carry_in_s = bus.cin;
        sub_mode_s = 1'b0;
    end
`endif

    assign in_ready_s  = (state_r == ST_IDLE) ||
                         ((state_r == ST_DONE) && bus.out_ready);
    assign accept_s    = bus.in_valid && in_ready_s;
    assign last_beat_s = (cnt_r == LAST_BEAT);

    // One digit of the carry chain; the carry into the top bit of this digit
    // falls out of a XOR b XOR sum, which on the last beat is the carry into
    // the operand MSB needed for signed overflow.
    always_comb begin
        digit_sum_s   = {1'b0, sa_r[DIGIT-1:0]} +
                        {1'b0, sb_r[DIGIT-1:0]} +
                        {{DIGIT{1'b0}}, carry_r};
        msb_cin_s     = sa_r[DIGIT-1] ^ sb_r[DIGIT-1] ^ digit_sum_s[DIGIT-1];
        final_carry_s = digit_sum_s[DIGIT];
    end

    // Shift network: operands move right one digit per beat, result digits
    // enter at the top so the least significant digit ends up at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_one_digit
            assign sa_next_s  = {WIDTH{1'b0}};
            assign sb_next_s  = {WIDTH{1'b0}};
            assign sum_next_s = digit_sum_s[DIGIT-1:0];
        end else begin : g_multi_digit
            assign sa_next_s  = {{DIGIT{1'b0}}, sa_r[WIDTH-1:DIGIT]};
            assign sb_next_s  = {{DIGIT{1'b0}}, sb_r[WIDTH-1:DIGIT]};
            assign sum_next_s = {digit_sum_s[DIGIT-1:0], sum_r[WIDTH-1:DIGIT]};
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: DONE can hand over straight to RUN when a new operand
    // pair arrives in the same cycle the result is taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, one digit per RUN cycle, hold otherwise so
    // the result stays stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_r    <= {WIDTH{1'b0}};
            sb_r    <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else if (accept_s) begin
            sa_r    <= bus.a;
            sb_r    <= b_in_s;
            carry_r <= carry_in_s;
            cnt_r   <= CNT_ZERO;
        end else if (state_r == ST_RUN) begin
            sa_r    <= sa_next_s;
            sb_r    <= sb_next_s;
            sum_r   <= sum_next_s;
            carry_r <= final_carry_s;
            cnt_r   <= cnt_r + CNT_ONE;
            if (last_beat_s) begin
                // Borrow-out is the inverted carry when subtracting.
                cout_r <= final_carry_s ^ sub_mode_s;
                ovf_r  <= msb_cin_s ^ final_carry_s;
            end else begin
                cout_r <= cout_r;
                ovf_r  <= ovf_r;
            end
        end else begin
            sa_r    <= sa_r;
            sb_r    <= sb_r;
            sum_r   <= sum_r;
            carry_r <= carry_r;
            cout_r  <= cout_r;
            ovf_r   <= ovf_r;
            cnt_r   <= cnt_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.busy      = (state_r == ST_RUN);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
//
// Three adders (WIDTH=16, DIGIT = 1, 4, 16) share clock and reset. Index k
// selects the instance: 0 -> DIGIT=1, 1 -> DIGIT=4, 2 -> DIGIT=16.
// Expected results come from signed/unsigned integer arithmetic on the
// operands. Honours MULTICYCLE_ADDER_SUB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

`ifdef MULTICYCLE_ADDER_SUB_EN
    localparam logic SUB_EN = 1'b1;
`else
    localparam logic SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]        iv;
    logic [2:0]        ic;
    logic [2:0]        isub;
    logic [2:0]        ordy;
    logic [2:0][15:0]  ia;
    logic [2:0][15:0]  ib;
    wire  [2:0]        o_ir;
    wire  [2:0]        o_ov;
    wire  [2:0]        o_busy;
    wire  [2:0]        o_cout;
    wire  [2:0]        o_ovf;
    wire  [2:0][15:0]  o_sum;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        multicycle_adder_if #(.WIDTH(16)) bus ();
        assign bus.in_valid  = iv[g];
        assign bus.a         = ia[g];
        assign bus.b         = ib[g];
        assign bus.cin       = ic[g];
        assign bus.sub       = isub[g];
        assign bus.out_ready = ordy[g];
        assign o_ir[g]       = bus.in_ready;
        assign o_ov[g]       = bus.out_valid;
        assign o_busy[g]     = bus.busy;
        assign o_cout[g]     = bus.cout;
        assign o_ovf[g]      = bus.ovf;
        assign o_sum[g]      = bus.sum;
        multicycle_adder #(.WIDTH(16), .DIGIT(DG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Reference: {cout, ovf, sum} from integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        int          r;
        int          sr;
        logic        co;
        logic        ov;
        logic [15:0] s;
        if (sub & SUB_EN) begin
            r  = int'(a) - int'(b) - int'(cin);
            sr = int'($signed(a)) - int'($signed(b)) - int'(cin);
            co = (r < 0);
        end else begin
            r  = int'(a) + int'(b) + int'(cin);
            sr = int'($signed(a)) + int'($signed(b)) + int'(cin);
            co = (r > 65535);
        end
        ov = (sr > 32767) || (sr < -32768);
        s  = r[15:0];
        return {co, ov, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation on instance k with a consumer that is always ready.
    task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv, output logic [17:0] res,
                          output int lat, output int busy_cnt);
        int guard;
        guard = 0;
        while (o_ir[k] !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL in_ready_wait[%0d]: in_ready never rose, required 1", k);
        end
        ia[k] = av; ib[k] = bv; ic[k] = cv; isub[k] = sv; iv[k] = 1'b1;
        tick();
        // Scramble the inputs: the operation in flight must not see them.
        iv[k] = 1'b0; ia[k] = 16'($urandom); ib[k] = 16'($urandom);
        ic[k] = ~cv; isub[k] = ~sv;
        lat = 0;
        busy_cnt = 0;
        while (o_ov[k] !== 1'b1 && lat < 40) begin
            if (o_busy[k] === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        res = {o_cout[k], o_ovf[k], o_sum[k]};
        tick();
    endtask

    task automatic test_reset();
        iv = 3'b000; ic = 3'b000; isub = 3'b000; ordy = 3'b111;
        ia = '0; ib = '0;
        rst_n = 1'b0;
        #12;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({o_ir[k], o_ov[k], o_busy[k], o_cout[k], o_ovf[k], o_sum[k]} !==
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
                bad++;
                $display("FAIL reset_state[%0d]: got ir=%b ov=%b busy=%b co=%b ovf=%b sum=%h, required 1 0 0 0 0 0000",
                         k, o_ir[k], o_ov[k], o_busy[k], o_cout[k], o_ovf[k], o_sum[k]);
            end
        end
        #8;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_directed();
        logic [15:0] ta[3];
        logic [15:0] tb_[3];
        logic [17:0] te[3];
        logic [17:0] res;
        int lat;
        int bc;
        ta  = '{16'h1234, 16'hFFFF, 16'h7FFF};
        tb_ = '{16'h4321, 16'h0001, 16'h0001};
        te  = '{{1'b0, 1'b0, 16'h5555}, {1'b1, 1'b0, 16'h0000}, {1'b0, 1'b1, 16'h8000}};
        for (int i = 0; i < 3; i++) begin
            run_op(1, ta[i], tb_[i], 1'b0, 1'b0, res, lat, bc);
            total++;
            if (res !== te[i]) begin
                bad++;
                $display("FAIL add_directed[%0d]: got {co,ovf,sum}=%h required %h", i, res, te[i]);
            end
            total++;
            if (lat !== 4 || bc !== 4) begin
                bad++;
                $display("FAIL add_latency[%0d]: got lat=%0d busy=%0d required 4 4", i, lat, bc);
            end
        end
    endtask

    task automatic test_sub();
        logic [17:0] res;
        logic [17:0] e0;
        logic [17:0] e1;
        int lat;
        int bc;
        if (SUB_EN) begin
            e0 = {1'b1, 1'b0, 16'hFFFE};
            e1 = {1'b0, 1'b1, 16'h7FFF};
        end else begin
            e0 = {1'b0, 1'b0, 16'h000C};
            e1 = {1'b0, 1'b0, 16'h8001};
        end
        run_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, res, lat, bc);
        total++;
        if (res !== e0) begin
            bad++;
            $display("FAIL sub_5_7: got %h required %h", res, e0);
        end
        run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, res, lat, bc);
        total++;
        if (res !== e1) begin
            bad++;
            $display("FAIL sub_8000_1: got %h required %h", res, e1);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] held;
        logic [17:0] res;
        int lat;
        ordy[1] = 1'b1;
        ia[1] = 16'h1111; ib[1] = 16'h2222; ic[1] = 1'b0; isub[1] = 1'b0; iv[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        lat = 0;
        while (o_ov[1] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (o_ov[1] === 1'b1) ordy[1] = 1'b0;
        end
        ordy[1] = 1'b0;
        held = {o_cout[1], o_ovf[1], o_sum[1]};
        total++;
        if (held !== {1'b0, 1'b0, 16'h3333}) begin
            bad++;
            $display("FAIL bp_first_result: got %h required %h", held, {2'b00, 16'h3333});
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({o_ov[1], o_ir[1], o_cout[1], o_ovf[1], o_sum[1]} !== {1'b1, 1'b0, held}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h required 1 0 %h",
                         c, o_ov[1], o_ir[1], {o_cout[1], o_ovf[1], o_sum[1]}, held);
            end
        end
        ia[1] = 16'hAAAA; ib[1] = 16'h1111; ic[1] = 1'b1; iv[1] = 1'b1; ordy[1] = 1'b1;
        #1;
        total++;
        if (o_ir[1] !== 1'b1) begin
            bad++;
            $display("FAIL bp_in_ready: got %b required 1", o_ir[1]);
        end
        tick();
        iv[1] = 1'b0;
        total++;
        if ({o_ov[1], o_busy[1]} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_accept: got ov=%b busy=%b required 0 1", o_ov[1], o_busy[1]);
        end
        lat = 0;
        while (o_ov[1] !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = {o_cout[1], o_ovf[1], o_sum[1]};
        total++;
        if (lat !== 4 || res !== model(16'hAAAA, 16'h1111, 1'b1, 1'b0)) begin
            bad++;
            $display("FAIL b2b_result: got lat=%0d res=%h required 4 %h",
                     lat, res, model(16'hAAAA, 16'h1111, 1'b1, 1'b0));
        end
        tick();
    endtask

    task automatic test_reset_midrun();
        int seen;
        logic [17:0] res;
        int lat;
        int bc;
        ia[1] = 16'h1234; ib[1] = 16'h4321; ic[1] = 1'b0; isub[1] = 1'b0; iv[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_ir[1], o_ov[1], o_busy[1], o_cout[1], o_ovf[1], o_sum[1]} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL midrun_reset: got ir=%b ov=%b busy=%b co=%b ovf=%b sum=%h, required 1 0 0 0 0 0000",
                     o_ir[1], o_ov[1], o_busy[1], o_cout[1], o_ovf[1], o_sum[1]);
        end
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_ov[1] !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midrun_no_result: got %0d out_valid cycles required 0", seen);
        end
        run_op(1, 16'h0001, 16'h0001, 1'b0, 1'b0, res, lat, bc);
        total++;
        if (res !== {1'b0, 1'b0, 16'h0002} || lat !== 4) begin
            bad++;
            $display("FAIL after_reset_op: got res=%h lat=%0d required 00002 4", res, lat);
        end
    endtask

    task automatic test_random(input int k, input int exp_lat);
        logic [15:0] av;
        logic [15:0] bv;
        logic        sv;
        logic [17:0] res;
        logic [17:0] exp_res;
        int lat;
        int bc;
        for (int i = 0; i < 1000; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            sv = 1'($urandom);
            exp_res = model(av, bv, i[0], sv);
            run_op(k, av, bv, i[0], sv, res, lat, bc);
            total++;
            if (res !== exp_res) begin
                bad++;
                $display("FAIL random_result[k=%0d i=%0d]: a=%h b=%h cin=%b sub=%b got %h required %h",
                         k, i, av, bv, i[0], sv, res, exp_res);
            end
            total++;
            if (lat !== exp_lat) begin
                bad++;
                $display("FAIL random_latency[k=%0d i=%0d]: got %0d required %0d", k, i, lat, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_directed();
        test_sub();
        test_back_to_back();
        test_reset_midrun();
        test_random(0, 16);
        test_random(1, 4);
        test_random(2, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
